// File: rtl/nbit_seq_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master issues start with operands; the slave (divider) returns
// busy/valid and the registered result fields.
interface nbit_seq_divider_if #(
  parameter int N = 5
);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           valid;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/nbit_seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient and remainder, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for start; last result held on the outputs
// RUN   | iterating, one quotient bit per cycle (busy=1)
// DONE  | one-cycle result strobe (valid=1); start accepted here too
module nbit_seq_divider #(
  parameter int N = 5
) (
  input logic              clk,
  input logic              rst_n,
  nbit_seq_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            dz_case;
  logic            ov_case;
  logic            step_last;

  // Partial remainder kept N bits wide: after every step R < divisor,
  // so the top bit of the (N+1)-bit R is always zero.
  logic [N-1:0]    r;
  logic [N-1:0]    l;
  logic [N-1:0]    q_sh;
  logic [N-1:0]    d;
  logic [CW-1:0]   cnt;

  logic [N:0]      t;
  logic            ge;
  logic [N-1:0]    r_step;
  logic [N-1:0]    q_step;

  logic [N-1:0]    quotient_q;
  logic [N-1:0]    remainder_q;
  logic            dz_q;
  logic            ov_q;

  assign t         = {r, l[N-1]};
  assign ge        = (t >= {1'b0, d});
  assign r_step    = N'(ge ? (t - {1'b0, d}) : t);
  assign q_step    = N'({q_sh, ge});
  assign step_last = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; error cases skip RUN and go straight to DONE.
  always_comb begin
    accept    = 1'b0;
    dz_case   = 1'b0;
    ov_case   = 1'b0;
    state_nxt = state;
    dz_case   = (bus.divisor == '0);
    ov_case   = !dz_case && (bus.dividend[2*N-1:N] >= bus.divisor);
    accept    = bus.start && (state != RUN);
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (dz_case || ov_case) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        state_nxt = step_last ? DONE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load, restoring iteration and result capture at entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      l           <= '0;
      q_sh        <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else if (accept) begin
      if (dz_case) begin
        quotient_q  <= '1;
        remainder_q <= bus.dividend[N-1:0];
        dz_q        <= 1'b1;
        ov_q        <= 1'b0;
      end else if (ov_case) begin
        quotient_q  <= '1;
        remainder_q <= '1;
        dz_q        <= 1'b0;
        ov_q        <= 1'b1;
      end else begin
        r    <= bus.dividend[2*N-1:N];
        l    <= bus.dividend[N-1:0];
        d    <= bus.divisor;
        q_sh <= '0;
        cnt  <= '0;
      end
    end else if (state == RUN) begin
      r    <= r_step;
      l    <= {l[N-2:0], 1'b0};
      q_sh <= q_step;
      cnt  <= cnt + CW'(1);
      if (step_last) begin
        quotient_q  <= q_step;
        remainder_q <= r_step;
        dz_q        <= 1'b0;
        ov_q        <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.valid       = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;
endmodule

// File: doc/nbit_seq_divider.md
Name: nbit_seq_divider

Overview:
- Sequential restoring divider; the inverse of the N-bit array multiplier in the systolic floating-point PE.
- Takes a 2N-bit dividend (product-width) and an N-bit divisor; returns an N-bit quotient and an N-bit remainder.
- Retires one quotient bit per clock behind a start/busy/valid handshake.
- Feeds mantissa division and normalisation paths in the floating-point PE.

Parameters:
- N, 5, operand width: divisor, quotient and remainder are N bits; dividend is 2N bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clk, accepted only when busy=0.
- dividend  input  2N  numerator; sampled with an accepted start.
- divisor  input  N  denominator; sampled with an accepted start.
- busy  output  1  high while an accepted division is iterating.
- valid  output  1  one-cycle pulse: quotient, remainder and flags are valid.
- quotient  output  N  result quotient; held until the next accepted start.
- remainder  output  N  result remainder; held until the next accepted start.
- div_by_zero  output  1  result flag: divisor was 0.
- overflow  output  1  result flag: true quotient does not fit in N bits.

Behaviour:
- Reset: rst_n low forces state=IDLE immediately, asynchronously. All outputs (busy, valid, quotient, remainder, div_by_zero, overflow) and internal registers go to 0. Reset mid-RUN aborts the operation; no valid pulse follows.
- States: IDLE, RUN, DONE.
- busy=1 only in RUN. valid=1 only in DONE. DONE lasts exactly one cycle.
- Start acceptance: start is accepted in IDLE or DONE (back-to-back allowed). In RUN, start is ignored, and dividend/divisor changes have no effect.
- Acceptance edge, divisor==0: next state DONE. quotient={N{1}}, remainder=dividend[N-1:0], div_by_zero=1, overflow=0.
- Acceptance edge, divisor!=0 and dividend[2N-1:N] >= divisor: next state DONE. quotient={N{1}}, remainder={N{1}}, overflow=1, div_by_zero=0.
- Acceptance edge, otherwise: next state RUN. Load partial remainder R (N+1 bits) = {0, dividend[2N-1:N]}. Load low shift register L = dividend[N-1:0]. Clear the quotient shift register and the step counter.
- Each RUN cycle:
  - T = {R[N-1:0], L[N-1]}; L <<= 1.
  - If T >= {0,divisor}: R = T - divisor, shift 1 into the quotient LSB.
  - Else: R = T, shift 0 into the quotient LSB.
  - Counter increments.
- After exactly N RUN cycles, go to DONE: quotient = shifted bits, remainder = R[N-1:0], both flags 0.
- Invariant: R < divisor holds before every step, so T fits in N+1 bits and no step subtraction underflows.
- Latency, start accepted at edge k:
  - Normal case: busy high after edges k..k+N-1; valid high after edge k+N, for one cycle.
  - Error case: valid high after edge k, for one cycle.
- Output registers (quotient, remainder, flags) update only at entry to DONE. They hold their values through IDLE and the following RUN.
- Flags clear only when the next result is written or on reset.
- Arithmetic is unsigned throughout.

Test Plan:
- N=5: dividend=273, divisor=21, start for 1 cycle -> busy for 5 cycles, then valid pulse; quotient=13, remainder=0, flags 0.
- N=5: dividend=100, divisor=7 -> quotient=14, remainder=2. Then dividend=991, divisor=31 -> quotient=31, remainder=30.
- N=5: dividend=37, divisor=0 -> valid 1 cycle after acceptance; div_by_zero=1, quotient=31, remainder=5, busy never asserted.
- N=5: dividend=1023, divisor=31 -> overflow=1, quotient=31, remainder=31, valid 1 cycle after acceptance. A following 100/7 clears overflow and gives 14 r 2.
- Start pulsed mid-RUN with different operands -> ignored; the original result appears on schedule. Start held high through DONE -> new operation accepted back-to-back, busy the next cycle.
- rst_n pulsed low asynchronously during RUN step 3 -> all outputs 0 at once, state IDLE, no valid pulse. Next start runs normally.
